// File: rtl/alarm_siren_ctrl.sv
// Armed/entry/siren alarm controller. It confirms the trig input over consecutive
// cycles, waits out an entry delay, runs a timed siren and counts events.
module alarm_siren_ctrl #(
    parameter int unsigned CONFIRM_CYC = 4,
    parameter int unsigned ENTRY_DLY   = 8,
    parameter int unsigned SIREN_CYC   = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       arm_i,
    input  logic       disarm_i,
    input  logic       trig_i,
    output logic       armed_o,
    output logic       pending_o,
    output logic       siren_o,
    output logic [3:0] event_cnt_o
);

    typedef enum logic [1:0] {StDisarmed, StArmed, StEntry, StSiren} state_e;

    localparam logic [CNT_W-1:0] ConfLast  = CNT_W'(CONFIRM_CYC - 1);
    localparam logic [CNT_W-1:0] EntryLast = CNT_W'(ENTRY_DLY - 1);
    localparam logic [CNT_W-1:0] SirenLast = CNT_W'(SIREN_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] conf_q, conf_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             armed_q, pending_q, siren_q;

    always_comb begin
        state_d = state_q;
        conf_d  = conf_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StDisarmed: begin
                conf_d = '0;
                tmr_d  = '0;
                if (arm_i && !disarm_i) state_d = StArmed;
            end
            StArmed: begin
                tmr_d = '0;
                if (disarm_i) begin
                    state_d = StDisarmed;
                    conf_d  = '0;
                end else if (!trig_i) begin
                    conf_d = '0;
                end else if (conf_q == ConfLast) begin
                    state_d = StEntry;
                    conf_d  = '0;
                end else begin
                    conf_d = conf_q + 1'b1;
                end
            end
            StEntry: begin
                conf_d = '0;
                if (disarm_i) begin
                    state_d = StDisarmed;
                    tmr_d   = '0;
                end else if (tmr_q == EntryLast) begin
                    state_d = StSiren;
                    tmr_d   = '0;
                    if (cnt_q != 4'd15) cnt_d = cnt_q + 4'd1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StSiren: begin
                conf_d = '0;
                if (disarm_i) begin
                    state_d = StDisarmed;
                    tmr_d   = '0;
                end else if (tmr_q == SirenLast) begin
                    state_d = StArmed;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = StDisarmed;
                conf_d  = '0;
                tmr_d   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StDisarmed;
            conf_q    <= '0;
            tmr_q     <= '0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            pending_q <= 1'b0;
            siren_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            conf_q    <= conf_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            armed_q   <= (state_d != StDisarmed);
            pending_q <= (state_d == StEntry);
            siren_q   <= (state_d == StSiren);
        end
    end

    assign armed_o     = armed_q;
    assign pending_o   = pending_q;
    assign siren_o     = siren_q;
    assign event_cnt_o = cnt_q;

endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// Scoreboard bench for alarm_siren_ctrl: directed scenarios plus random traffic,
// checked against a run-length/age reference model.
module tb_alarm_siren_ctrl;

    localparam int unsigned CONF  = 4;
    localparam int unsigned ENTRY = 8;
    localparam int unsigned SIREN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       arm = 1'b0;
    logic       disarm = 1'b0;
    logic       trig = 1'b0;
    logic       armed, pending, siren;
    logic [3:0] event_cnt;

    int tests  = 0;
    int fails  = 0;
    int cycle  = 0;
    logic [6:0] exp_q[$];

    // Reference model: mode 0=off 1=watching 2=entry 3=siren
    int m_mode   = 0;
    int m_streak = 0;
    int m_age    = 0;
    int m_events = 0;

    alarm_siren_ctrl #(
        .CONFIRM_CYC(CONF),
        .ENTRY_DLY  (ENTRY),
        .SIREN_CYC  (SIREN),
        .CNT_W      (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .arm_i      (arm),
        .disarm_i   (disarm),
        .trig_i     (trig),
        .armed_o    (armed),
        .pending_o  (pending),
        .siren_o    (siren),
        .event_cnt_o(event_cnt)
    );

    always #5 clk = ~clk;

    task automatic model(input bit r, input bit a, input bit d, input bit t);
        if (r) begin
            m_mode = 0; m_streak = 0; m_age = 0; m_events = 0;
        end else if (m_mode == 0) begin
            if (a && !d) begin m_mode = 1; m_streak = 0; end
        end else if (d) begin
            m_mode = 0; m_streak = 0; m_age = 0;
        end else if (m_mode == 1) begin
            m_streak = t ? m_streak + 1 : 0;
            if (m_streak == CONF) begin m_mode = 2; m_age = 0; m_streak = 0; end
        end else if (m_mode == 2) begin
            m_age++;
            if (m_age == ENTRY) begin
                m_mode = 3; m_age = 0;
                m_events = (m_events < 15) ? m_events + 1 : 15;
            end
        end else begin
            m_age++;
            if (m_age == SIREN) begin m_mode = 1; m_age = 0; m_streak = 0; end
        end
    endtask

    task automatic step(input bit r, input bit a, input bit d, input bit t);
        logic [6:0] e;
        @(negedge clk);
        #1;
        rst = r; arm = a; disarm = d; trig = t;
        model(r, a, d, t);
        e = {m_mode != 0, m_mode == 2, m_mode == 3, 4'(m_events)};
        @(posedge clk);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit t);
        for (int i = 0; i < n; i++) step(0, 0, 0, t);
    endtask

    // Monitor: outputs are valid every cycle, so one expected entry per edge.
    initial begin
        logic [6:0] e;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {armed, pending, siren, event_cnt};
                tests++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL outputs cycle %0d: got armed=%b pending=%b siren=%b cnt=%0d, expected armed=%b pending=%b siren=%b cnt=%0d",
                             cycle, got[6], got[5], got[4], got[3:0], e[6], e[5], e[4], e[3:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: normal alarm
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        idle(CONF, 1);
        idle(ENTRY + SIREN + 3, 0);
        // 2: glitch rejection
        idle(3, 1); idle(1, 0); idle(3, 1); idle(1, 0);
        // 3: disarm on third entry cycle, later trig ignored
        idle(CONF, 1);
        idle(2, 0);
        step(0, 0, 1, 0);
        idle(8, 1);
        // 4: arm+disarm together, then disarm at entry expiry
        step(0, 1, 1, 0);
        idle(2, 0);
        step(0, 1, 0, 0);
        idle(CONF, 1);
        idle(ENTRY - 1, 0);
        step(0, 0, 1, 0);
        idle(SIREN, 0);
        // 5: reset on fifth siren cycle
        step(0, 1, 0, 0);
        idle(CONF, 1);
        idle(ENTRY, 0);
        idle(4, 0);
        step(1, 0, 0, 0);
        idle(3, 1);
        // 6: saturation over 17 full alarms
        step(0, 1, 0, 0);
        for (int k = 0; k < 17; k++) begin
            idle(CONF, 1);
            idle(ENTRY + SIREN + 1, 0);
        end
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7);
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
